// File: rtl/data_sram_responder_pkg.sv
// Address map and shared helpers for the data SRAM responder.
// Holds the MMIO window base, register offsets, reset values and the byte-merge helper.
package data_sram_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hBFAF_0000;

  localparam logic [15:0] LED_OFF   = 16'h0000;
  localparam logic [15:0] SW_OFF    = 16'h0004;
  localparam logic [15:0] TIMER_OFF = 16'h0008;
  localparam logic [15:0] CMP_OFF   = 16'h000C;
  localparam logic [15:0] STAT_OFF  = 16'h0010;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  we);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Core data SRAM port: request (en/we/addr/wdata) from the core, rdata back one cycle later.
// No handshake: the responder accepts an access every cycle.
interface data_sram_responder_if;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/data_sram_responder_sram_bank_be.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port.
// Read data lands one cycle after a read and holds until the next read; never stalls.
module data_sram_responder_sram_bank_be #(
  parameter int RAM_AW = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**RAM_AW];
  logic [31:0] rdata_q, rdata_d;

  // Storage is deliberately left unreset; only the output register clears.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en && (we == 4'b0000)) rdata_d = mem[addr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: decodes core accesses to on-chip RAM or LED/switch/timer/CMP/STATUS MMIO.
// Read data returns exactly one cycle after the request; one access per cycle, no backpressure.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter int          SW_W      = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  data_sram_responder_if.slave  bus,
  output logic [15:0]           led,
  input  logic [SW_W-1:0]       switch,
  output logic                  timer_irq
);

  logic        is_mmio, rd_req, wr_req;
  logic [15:0] off;
  logic        wr_led, wr_timer, wr_cmp, wr_stat;
  logic [31:0] mmio_val, ram_rdata;

  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic        sel_mmio_q, sel_mmio_d;

  assign is_mmio  = (bus.addr[31:16] == MMIO_BASE[31:16]);
  assign off      = bus.addr[15:0];
  assign rd_req   = bus.en && (bus.we == 4'b0000);
  assign wr_req   = bus.en && (bus.we != 4'b0000);
  assign wr_led   = wr_req && is_mmio && (off == LED_OFF);
  assign wr_timer = wr_req && is_mmio && (off == TIMER_OFF);
  assign wr_cmp   = wr_req && is_mmio && (off == CMP_OFF);
  assign wr_stat  = wr_req && is_mmio && (off == STAT_OFF);

  data_sram_responder_sram_bank_be #(.RAM_AW(RAM_AW)) u_bank (
    .clk    (clk),
    .resetn (resetn),
    .en     (bus.en && !is_mmio),
    .we     (bus.we),
    .addr   (bus.addr[RAM_AW+1:2]),
    .wdata  (bus.wdata),
    .rdata  (ram_rdata)
  );

  // MMIO read value is taken from pre-edge register state (timer before its increment).
  always_comb begin
    case (off)
      LED_OFF:   mmio_val = {16'h0000, led_q};
      SW_OFF:    mmio_val = {{(32-SW_W){1'b0}}, switch};
      TIMER_OFF: mmio_val = timer_q;
      CMP_OFF:   mmio_val = cmp_q;
      STAT_OFF:  mmio_val = {31'b0, match_q};
      default:   mmio_val = '0;
    endcase
  end

  always_comb begin
    led_d        = led_q;
    timer_d      = timer_q + 32'd1;
    cmp_d        = cmp_q;
    match_d      = match_q;
    mmio_rdata_d = mmio_rdata_q;
    sel_mmio_d   = sel_mmio_q;

    if (wr_led) begin
      if (bus.we[0]) led_d[7:0]  = bus.wdata[7:0];
      if (bus.we[1]) led_d[15:8] = bus.wdata[15:8];
    end
    if (wr_timer) timer_d = be_merge(timer_q, bus.wdata, bus.we);
    if (wr_cmp)   cmp_d   = be_merge(cmp_q, bus.wdata, bus.we);

    // Match tracks the registered timer/CMP pair; a coincident set beats a W1C clear.
    if (wr_stat && bus.we[0] && bus.wdata[0]) match_d = 1'b0;
    if (timer_d == cmp_d) match_d = 1'b1;

    if (rd_req) begin
      sel_mmio_d = is_mmio;
      if (is_mmio) mmio_rdata_d = mmio_val;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q        <= '0;
      timer_q      <= '0;
      cmp_q        <= CMP_RST;
      match_q      <= 1'b0;
      mmio_rdata_q <= '0;
      sel_mmio_q   <= 1'b0;
    end else begin
      led_q        <= led_d;
      timer_q      <= timer_d;
      cmp_q        <= cmp_d;
      match_q      <= match_d;
      mmio_rdata_q <= mmio_rdata_d;
      sel_mmio_q   <= sel_mmio_d;
    end
  end

  assign bus.rdata = sel_mmio_q ? mmio_rdata_q : ram_rdata;
  assign led       = led_q;
  assign timer_irq = match_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed and randomized checks of data_sram_responder against a behavioural RAM/MMIO model.
module tb_data_sram_responder;

  localparam logic [31:0] MM = 32'hBFAF_0000;

  logic       clk = 1'b0;
  logic       resetn;
  logic [15:0] led;
  logic [7:0]  sw;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] ram_m   [int];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  data_sram_responder_if bus ();

  data_sram_responder #(.RAM_AW(14), .SW_W(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .led       (led),
    .switch    (sw),
    .timer_irq (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, return 1 time unit after the rising edge.
  task automatic cyc(input logic en, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wdata);
    @(negedge clk);
    bus.en    = en;
    bus.we    = we;
    bus.addr  = addr;
    bus.wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = o;
    if (we[0]) r[7:0]   = n[7:0];
    if (we[1]) r[15:8]  = n[15:8];
    if (we[2]) r[23:16] = n[23:16];
    if (we[3]) r[31:24] = n[31:24];
    return r;
  endfunction

  initial begin
    bus.en = 1'b0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    sw = 8'h00;
    resetn = 1'b0;
    #12;
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_led", led, 32'h0);
    chk("reset_irq", irq, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Reset value of CMP
    cyc(1'b1, 4'b0000, MM + 32'h0C, 32'h0);
    chk("cmp_reset_read", bus.rdata, 32'hFFFF_FFFF);
    chk("led_after_reset", led, 32'h0);
    chk("irq_after_reset", irq, 32'h0);

    // Byte-strobed RAM write then read
    cyc(1'b1, 4'b1111, 32'h40, 32'h1122_3344);
    cyc(1'b1, 4'b0010, 32'h40, 32'h0000_AA00);
    chk("rdata_hold_over_writes", bus.rdata, 32'hFFFF_FFFF);
    cyc(1'b1, 4'b0000, 32'h40, 32'h0);
    chk("ram_byte_merge", bus.rdata, 32'h1122_AA44);

    // Address aliasing above the RAM index bits
    cyc(1'b1, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF);
    cyc(1'b1, 4'b0000, 32'h0001_0000, 32'h0);
    chk("ram_alias", bus.rdata, 32'hDEAD_BEEF);
    idle();
    chk("rdata_hold_idle", bus.rdata, 32'hDEAD_BEEF);

    // LED and SWITCH
    cyc(1'b1, 4'b1111, MM + 32'h00, 32'hFFFF_A5A5);
    chk("led_out", led, 32'h0000_A5A5);
    cyc(1'b1, 4'b0000, MM + 32'h00, 32'h0);
    chk("led_read", bus.rdata, 32'h0000_A5A5);
    sw = 8'h3C;
    cyc(1'b1, 4'b1111, MM + 32'h04, 32'h1234_5678);
    cyc(1'b1, 4'b0000, MM + 32'h04, 32'h0);
    chk("switch_read", bus.rdata, 32'h0000_003C);
    cyc(1'b1, 4'b0000, MM + 32'h20, 32'h0);
    chk("unmapped_read", bus.rdata, 32'h0);

    // Timer load, read-before-increment, wrap
    cyc(1'b1, 4'b1111, MM + 32'h08, 32'hFFFF_FFFE);
    idle();
    cyc(1'b1, 4'b0000, MM + 32'h08, 32'h0);
    chk("timer_read", bus.rdata, 32'hFFFF_FFFF);
    idle();
    cyc(1'b1, 4'b0000, MM + 32'h08, 32'h0);
    chk("timer_wrap", bus.rdata, 32'h0000_0001);
    // The timer passed the reset CMP value on its way to the wrap
    chk("irq_at_reset_cmp", irq, 32'h1);

    // Park the timer far away, set CMP, clear the stale match
    cyc(1'b1, 4'b1111, MM + 32'h08, 32'h0000_1000);
    cyc(1'b1, 4'b1111, MM + 32'h0C, 32'd20);
    cyc(1'b1, 4'b0001, MM + 32'h10, 32'h1);
    chk("status_clear", irq, 32'h0);

    // Timer load of 10 against CMP 20
    cyc(1'b1, 4'b1111, MM + 32'h08, 32'd10);
    for (int k = 1; k < 10; k++) idle();
    chk("irq_before_match", irq, 32'h0);
    idle();
    chk("irq_at_match", irq, 32'h1);
    cyc(1'b1, 4'b0000, MM + 32'h10, 32'h0);
    chk("status_read", bus.rdata, 32'h1);

    // Clear coinciding with a fresh match: set wins
    cyc(1'b1, 4'b1111, MM + 32'h08, 32'd18);
    idle();
    cyc(1'b1, 4'b0001, MM + 32'h10, 32'h1);
    chk("set_beats_clear", irq, 32'h1);
    cyc(1'b1, 4'b0001, MM + 32'h10, 32'h1);
    chk("plain_clear", irq, 32'h0);

    // Randomized RAM traffic with random (non-MMIO) upper address bits
    for (int i = 0; i < 16; i++) begin
      exp_v = $urandom;
      cyc(1'b1, 4'b1111, 32'((32 + i) * 4), exp_v);
      ram_m[32 + i] = exp_v;
    end
    for (int n = 0; n < 300; n++) begin
      int          idx;
      logic [31:0] hi, addr, wd;
      logic [3:0]  we;
      idx  = 32 + int'($urandom_range(0, 15));
      hi   = $urandom;
      if (hi[31:16] == 16'hBFAF) hi[31:16] = 16'h0000;
      addr = {hi[31:16], 16'(idx * 4)};
      if ($urandom_range(0, 1) == 1) begin
        we = 4'($urandom_range(1, 15));
        wd = $urandom;
        cyc(1'b1, we, addr, wd);
        ram_m[idx] = merge(ram_m[idx], wd, we);
      end else begin
        cyc(1'b1, 4'b0000, addr, 32'h0);
        chk("rand_ram_read", bus.rdata, ram_m[idx]);
      end
    end

    // Reset asserted while a read is pending
    @(negedge clk);
    bus.en = 1'b1; bus.we = 4'b0000; bus.addr = MM; bus.wdata = '0;
    #2 resetn = 1'b0;
    #1;
    chk("reset_mid_read_rdata", bus.rdata, 32'h0);
    chk("reset_mid_read_led", led, 32'h0);
    @(negedge clk);
    bus.en = 1'b0;
    resetn = 1'b1;
    cyc(1'b1, 4'b0000, MM + 32'h00, 32'h0);
    chk("led_read_after_reset", bus.rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
